// File: rtl/memoria_datos_v2.sv
// memoria_datos_v2: byte-addressed data memory, big-endian, with a fixed
// request-to-response latency and per-byte "written" tracking.
//
// Build option: define MEMORIA_DATOS_SIGN_EXT_EN to sign-extend byte and
// halfword reads; the default build zero-extends them.
//
// state | meaning
// IDLE  | ready=1, waiting for req
// WAIT  | request captured, counting down the programmed latency
// RESP  | access already committed; done/error are issued on leaving
//
// Timing: accept at edge E0, commit (write or datoOut update) at E0+LATENCY,
// done/error pulse and ready return at E0+LATENCY+1.
module memoria_datos_v2 #(
  parameter int SIZE    = 64,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        memWr,
  input  logic [1:0]  mode,
  input  logic [31:0] address,
  input  logic [31:0] datoIn,
  output logic [31:0] datoOut,
  output logic        ready,
  output logic        done,
  output logic        error
);

  localparam int AW = $clog2(SIZE);
  localparam bit ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        r_memwr;
  logic [1:0]  r_mode;
  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic        resp_err;

  logic [7:0]      mem [SIZE];
  logic [SIZE-1:0] wflag;

  logic        a_memwr;
  logic [1:0]  a_mode;
  logic [31:0] a_addr;
  logic [31:0] a_din;
  logic        commit;
  logic        acc_err;
  logic [2:0]  nbytes;
  logic [32:0] last_addr;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [7:0]  rb0, rb1, rb2, rb3;
  logic [31:0] rdata;

  // With zero latency the commit happens on the accepting edge, so the live
  // inputs are used; otherwise the captured request is used.
  always_comb begin
    if (state == IDLE) begin
      a_memwr = memWr;
      a_mode  = mode;
      a_addr  = address;
      a_din   = datoIn;
    end else begin
      a_memwr = r_memwr;
      a_mode  = r_mode;
      a_addr  = r_addr;
      a_din   = r_din;
    end
  end

  // Commit strobe: the edge that enters RESP.
  assign commit = (ZERO_LAT && (state == IDLE) && req) ||
                  ((state == WAIT) && (cnt == 3'd1));

  // Access size and legality decode.
  always_comb begin
    case (a_mode)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    last_addr = {1'b0, a_addr} + 33'(nbytes) - 33'd1;
    acc_err   = (a_mode == 2'b11) ||
                ((a_mode == 2'b01) && a_addr[0]) ||
                ((a_mode == 2'b10) && (a_addr[1:0] != 2'b00)) ||
                (last_addr >= 33'(SIZE));
  end

  assign i0 = a_addr[AW-1:0];
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);

  // Bytes never written since reset read as zero.
  assign rb0 = wflag[i0] ? mem[i0] : 8'h00;
  assign rb1 = wflag[i1] ? mem[i1] : 8'h00;
  assign rb2 = wflag[i2] ? mem[i2] : 8'h00;
  assign rb3 = wflag[i3] ? mem[i3] : 8'h00;

  // Big-endian read assembly with optional sign extension of narrow reads.
  always_comb begin
    rdata = 32'h0;
    case (a_mode)
`ifdef MEMORIA_DATOS_SIGN_EXT_EN
      2'b00:   rdata = {{24{rb0[7]}}, rb0};
      2'b01:   rdata = {{16{rb0[7]}}, rb0, rb1};
`else
      2'b00:   rdata = {24'h0, rb0};
      2'b01:   rdata = {16'h0, rb0, rb1};
`endif
      default: rdata = {rb0, rb1, rb2, rb3};
    endcase
  end

  // Storage array: written only by a legal write commit; contents are
  // masked by the written flags, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (commit && !rst && !a_memwr && !acc_err) begin
      case (a_mode)
        2'b00: mem[i0] <= a_din[7:0];
        2'b01: begin
          mem[i0] <= a_din[15:8];
          mem[i1] <= a_din[7:0];
        end
        default: begin
          mem[i0] <= a_din[31:24];
          mem[i1] <= a_din[23:16];
          mem[i2] <= a_din[15:8];
          mem[i3] <= a_din[7:0];
        end
      endcase
    end
  end

  // Control FSM with registered handshake outputs, read data and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      r_memwr  <= 1'b1;
      r_mode   <= 2'b00;
      r_addr   <= 32'h0;
      r_din    <= 32'h0;
      resp_err <= 1'b0;
      datoOut  <= 32'h0;
      ready    <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      wflag    <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;

      if (commit) begin
        if (acc_err) begin
          datoOut  <= 32'h0;
          resp_err <= 1'b1;
        end else begin
          resp_err <= 1'b0;
          if (a_memwr) begin
            datoOut <= rdata;
          end else begin
            case (a_mode)
              2'b00: wflag[i0] <= 1'b1;
              2'b01: begin
                wflag[i0] <= 1'b1;
                wflag[i1] <= 1'b1;
              end
              default: begin
                wflag[i0] <= 1'b1;
                wflag[i1] <= 1'b1;
                wflag[i2] <= 1'b1;
                wflag[i3] <= 1'b1;
              end
            endcase
          end
        end
      end

      case (state)
        IDLE: begin
          if (req) begin
            r_memwr <= memWr;
            r_mode  <= mode;
            r_addr  <= address;
            r_din   <= datoIn;
            cnt     <= 3'(LATENCY);
            ready   <= 1'b0;
            state   <= ZERO_LAT ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b1;
          error <= resp_err;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/memoria_datos_v2.md
MEMORIA_DATOS_V2 -- requirements
Module: memoria_datos_v2

Interface
REQ-001 SHALL have parameter SIZE, default 64: memory depth in bytes; power of two, >= 4.
REQ-002 SHALL have parameter LATENCY, default 1: wait cycles inserted between request acceptance and response; legal range 0..7.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  1  access request; sampled only while ready=1.
REQ-006 SHALL have port memWr  input  1  active-low write select: 0 = write, 1 = read.
REQ-007 SHALL have port mode  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port address  input  32  byte address.
REQ-009 SHALL have port datoIn  input  32  write data; right-aligned for byte and halfword accesses.
REQ-010 SHALL have port datoOut  output  32  registered read data.
REQ-011 SHALL have port ready  output  1  block idle; able to accept a request.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port error  output  1  access rejected; meaningful only while done=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP; ready=1 only in IDLE.
REQ-015 SHALL, in IDLE with req=1 at a rising edge, register memWr, mode, address and datoIn, and load the wait counter with LATENCY.
REQ-016 SHALL go IDLE->WAIT on acceptance when LATENCY>0, and IDLE->RESP when LATENCY=0.
REQ-017 SHALL, in WAIT, decrement the counter each cycle, go to RESP when the counter reaches 1, and ignore req.
REQ-018 SHALL, in RESP, drive done=1 for exactly one cycle, then go to IDLE; done rises at accepting edge + LATENCY + 1.
REQ-019 SHALL commit a write on the edge entering RESP, using big-endian order.
- word: mem[A..A+3] = datoIn[31:24], [23:16], [15:8], [7:0].
- half: mem[A] = datoIn[15:8], mem[A+1] = datoIn[7:0].
- byte: mem[A] = datoIn[7:0].
REQ-020 SHALL update datoOut on the same edge for reads.
- byte: {24'h0, mem[A]}.
- half: {16'h0, mem[A], mem[A+1]}.
- word: all four bytes, same order as REQ-019.
REQ-021 SHALL keep one written flag per byte, set on write and cleared by reset; a byte whose flag is clear SHALL read as 8'h00.
REQ-022 SHALL flag error=1 with done, perform no write, and set datoOut=0 on any of:
- mode=11;
- halfword with address[0]=1;
- word with address[1:0]!=0;
- address+bytes-1 >= SIZE.
REQ-023 SHALL leave datoOut unchanged after a successful write.
REQ-024 SHALL hold datoOut until the next completed read or error.
REQ-025 SHALL return newly written data for a read accepted immediately after a write completes.
REQ-026 SHALL ignore changes on the request inputs while ready=0.

Reset
REQ-027 SHALL, while rst=1 and independently of clk, force: state IDLE, ready=1, done=0, error=0, datoOut=0, counter=0, all written flags cleared.
REQ-028 SHALL, on reset during WAIT or RESP, abort the access; the pending write SHALL NOT be committed.

Configuration
REQ-029 SHALL, with MEMORIA_DATOS_SIGN_EXT_EN defined, sign-extend byte reads from bit 7 and halfword reads from bit 15.
REQ-030 SHALL, without MEMORIA_DATOS_SIGN_EXT_EN, zero-extend byte and halfword reads; word accesses are unaffected either way.

Verification (SIZE=64, LATENCY=2)
REQ-031 SHALL cover: write word 0x12345678 @0x08, then read word @0x08 -> done at accepting edge+3, datoOut=0x12345678, error=0.
REQ-032 SHALL cover: read byte @0x09 and half @0x0A after REQ-031 -> datoOut 0x00000034, then 0x00005678.
REQ-033 SHALL cover: write byte 0x80 @0x10, read byte @0x10 -> 0xFFFFFF80 with macro, 0x00000080 without.
REQ-034 SHALL cover: read word @0x06, then word @0x3E -> both error=1, datoOut=0, memory unchanged.
REQ-035 SHALL cover: read word @0x20 (never written) -> 0x00000000; then assert rst during WAIT of write 0xAAAAAAAA @0x20, re-read -> 0x00000000.
REQ-036 SHALL cover: req held high continuously -> accepts only in IDLE, one access per LATENCY+2 cycles, ready=0 between.
